gates_bist_ctrl: RTL and testbench
==================================

GATES_BIST_CTRL -- requirements
Module: gates_bist_ctrl

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYCLES, default 2, wait cycles between applying a vector and checking it (legal range 0..15).
REQ-002 The block SHALL have one clock, clk; reset is synchronous and active-high, named rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to run one self-test pass; sampled only in IDLE.
REQ-006 fault_inj  input  1  when high in CHECK, inverts the captured and_op bit before comparison (checker self-test).
REQ-007 busy  output  1  high while in APPLY, SETTLE or CHECK.
REQ-008 done  output  1  single-cycle pulse at end of a pass.
REQ-009 pass  output  1  high when the last completed pass had zero mismatches; held until the next accepted start.
REQ-010 fail_mask  output  4  bit i set when vector i had at least one mismatch.
REQ-011 err_cnt  output  4  total mismatched output bits in the pass (0..12).
REQ-012 cur_vec  output  2  index of the vector currently applied; {a,b} = cur_vec.

Function
REQ-013 The block SHALL instantiate one mux-based gate unit (and_op, or_op, not_op) and drive its a/b inputs from registered cur_vec bits.
REQ-014 FSM states SHALL be IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-015 IDLE->APPLY on start=1; the same edge clears cur_vec, fail_mask, err_cnt and pass.
REQ-016 APPLY SHALL last 1 cycle, then go to SETTLE, or directly to CHECK when SETTLE_CYCLES=0.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, timed by a down-counter loaded in APPLY.
REQ-018 CHECK SHALL last 1 cycle and compare and_op/or_op/not_op against expected a&b, a|b, ~a.
REQ-019 In CHECK, err_cnt SHALL add the number of mismatching bits (0..3), and fail_mask[cur_vec] SHALL be set if that number is nonzero.
REQ-020 CHECK->APPLY with cur_vec+1 when cur_vec<3; CHECK->DONE when cur_vec=3.
REQ-021 DONE SHALL last 1 cycle with done=1, load pass = (final err_cnt==0), then go to IDLE.
REQ-022 done SHALL assert exactly 4*(SETTLE_CYCLES+2) cycles after the edge that samples start (16 cycles at default).
REQ-023 start SHALL be ignored in every state except IDLE; no request is queued.
REQ-024 err_cnt SHALL NOT wrap; maximum reachable value is 12.
REQ-025 fail_mask, err_cnt and pass SHALL hold their values in IDLE after a pass.

Reset
REQ-026 rst SHALL override all other inputs and take effect at the next edge from any state, including mid-pass.
REQ-027 On rst: state=IDLE, busy=0, done=0, pass=0, fail_mask=0, err_cnt=0, cur_vec=0, settle counter=0, gate inputs a=b=0.
REQ-028 A start asserted together with rst SHALL be ignored.

Structure
REQ-029 State encodings, the vector count (4) and the expected-value function SHALL live in a shared package, gates_bist_pkg.
REQ-030 The gate unit SHALL be the single sub-module, named gates, with ports a, b, and_op, or_op, not_op.

Verification
REQ-031 Default run, start pulse, fault_inj=0: done at cycle 16, pass=1, fail_mask=4'b0000, err_cnt=0, and cur_vec steps 0,1,2,3.
REQ-032 fault_inj=1 for the whole pass: pass=0, fail_mask=4'b1111, err_cnt=4.
REQ-033 fault_inj=1 only during the vector-2 CHECK: fail_mask=4'b0100, err_cnt=1, pass=0.
REQ-034 SETTLE_CYCLES=0: done at cycle 8 after start with pass=1; start pulses at cycles 3 and 5 cause no restart or extra done.
REQ-035 rst at cycle 7 of a pass: next cycle all outputs are zero and the state is IDLE; a following start completes a normal pass with pass=1.

Source files
------------

// File: rtl/gates_bist_pkg.sv
// Shared definitions for the gate-unit self-test controller.
//   state_t       : controller FSM states
//   NUM_VECS      : number of exhaustive {a,b} test vectors
//   LAST_VEC      : index of the final vector
//   expected_ops  : golden {and, or, not} result for a given a/b
//   count_ones3   : number of set bits in a 3-bit mismatch word
package gates_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int         NUM_VECS = 4;
    localparam logic [1:0] LAST_VEC = 2'(NUM_VECS - 1);

    // Bit order matches the comparison word: {and, or, not}.
    function automatic logic [2:0] expected_ops(input logic a, input logic b);
        return {a & b, a | b, ~a};
    endfunction

    function automatic logic [1:0] count_ones3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/gates.sv
// Mux-based elementary gate unit under test.
//   a, b    : operand inputs
//   and_op  : a & b
//   or_op   : a | b
//   not_op  : ~a
module gates (
    input  logic a,
    input  logic b,
    output logic and_op,
    output logic or_op,
    output logic not_op
);

    // Each gate is built from a 2:1 mux selected by a.
    assign and_op = a ? b    : 1'b0;
    assign or_op  = a ? 1'b1 : b;
    assign not_op = a ? 1'b0 : 1'b1;

endmodule

// File: rtl/gates_bist_ctrl.sv
// Built-in self-test controller for the gates unit. Walks all four {a,b}
// vectors, waits SETTLE_CYCLES after applying each one, compares the three
// gate outputs with the golden values and accumulates a per-vector fail mask
// and a total mismatch count.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   start      : begin one pass (honoured only in IDLE)
//   fault_inj  : invert captured and_op during CHECK (checker self-test)
//   busy       : high in APPLY / SETTLE / CHECK
//   done       : one-cycle pulse at the end of a pass
//   pass       : last completed pass had no mismatches
//   fail_mask  : bit i set when vector i mismatched
//   err_cnt    : total mismatching output bits in the pass
//   cur_vec    : vector currently applied, {a,b} = cur_vec
module gates_bist_ctrl
    import gates_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       fault_inj,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [3:0] err_cnt,
    output logic [1:0] cur_vec
);

    // Counter is loaded with one less than the dwell so SETTLE exits on zero.
    localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic       NO_SETTLE   = (SETTLE_CYCLES == 0);

    state_t     state, next_state;
    logic [3:0] settle_cnt;

    logic       a, b;
    logic       and_op, or_op, not_op;
    logic [2:0] observed;
    logic [2:0] miss;
    logic [1:0] miss_cnt;
    logic [4:0] err_sum;

    // Gate inputs come straight from the registered vector index.
    assign a = cur_vec[1];
    assign b = cur_vec[0];

    gates u_gates (
        .a      (a),
        .b      (b),
        .and_op (and_op),
        .or_op  (or_op),
        .not_op (not_op)
    );

    always_comb begin
        observed = {and_op ^ fault_inj, or_op, not_op};
        miss     = observed ^ expected_ops(a, b);
        miss_cnt = count_ones3(miss);
        err_sum  = {1'b0, err_cnt} + {3'b000, miss_cnt};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_APPLY;
            end
            ST_APPLY: begin
                busy       = 1'b1;
                next_state = NO_SETTLE ? ST_CHECK : ST_SETTLE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == 4'd0) next_state = ST_CHECK;
            end
            ST_CHECK: begin
                busy       = 1'b1;
                next_state = (cur_vec == LAST_VEC) ? ST_DONE : ST_APPLY;
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_vec    <= 2'd0;
            fail_mask  <= 4'd0;
            err_cnt    <= 4'd0;
            pass       <= 1'b0;
            settle_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_vec   <= 2'd0;
                        fail_mask <= 4'd0;
                        err_cnt   <= 4'd0;
                        pass      <= 1'b0;
                    end
                end
                ST_APPLY: settle_cnt <= SETTLE_LOAD;
                ST_SETTLE: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                end
                ST_CHECK: begin
                    if (miss_cnt != 2'd0) begin
                        fail_mask[cur_vec] <= 1'b1;
                        // Cannot exceed 12 in practice; clamp rather than wrap.
                        err_cnt <= err_sum[4] ? 4'hF : err_sum[3:0];
                    end
                    if (cur_vec != LAST_VEC) cur_vec <= cur_vec + 2'd1;
                end
                ST_DONE: pass <= (err_cnt == 4'd0);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gates_bist_ctrl.sv
module tb_gates_bist_ctrl;

    typedef struct {
        logic       pass;
        logic [3:0] mask;
        logic [3:0] err;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-settle instance
    logic       rst, start, fault_inj;
    logic       busy, done, pass;
    logic [3:0] fail_mask, err_cnt;
    logic [1:0] cur_vec;

    // Zero-settle instance
    logic       rst0, start0, fault0;
    logic       busy0, done0, pass0;
    logic [3:0] fail_mask0, err_cnt0;
    logic [1:0] cur_vec0;

    gates_bist_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .fault_inj(fault_inj),
        .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
        .err_cnt(err_cnt), .cur_vec(cur_vec)
    );

    gates_bist_ctrl #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .start(start0), .fault_inj(fault0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_mask(fail_mask0),
        .err_cnt(err_cnt0), .cur_vec(cur_vec0)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Golden model: inj[v] says whether and_op is inverted in vector v's CHECK.
    function automatic exp_t model(input logic [3:0] inj, input int settle);
        exp_t       e;
        logic [2:0] good, seen, diff;
        logic [1:0] v;
        e.mask = 4'd0;
        e.err  = 4'd0;
        for (int i = 0; i < 4; i++) begin
            v    = 2'(i);
            good = {v[1] & v[0], v[1] | v[0], ~v[1]};
            seen = good ^ {inj[i], 2'b00};
            diff = good ^ seen;
            for (int k = 0; k < 3; k++) e.err = e.err + 4'(diff[k]);
            if (diff != 3'b000) e.mask[i] = 1'b1;
        end
        e.pass = (e.err == 4'd0);
        e.lat  = 4 * (settle + 2);
        return e;
    endfunction

    // mode 0: no fault, 1: fault for the whole pass, 2: fault on vector 2 only
    task automatic run_a(input int mode, input string nm);
        exp_t       e;
        int         cnt;
        logic [1:0] seq[$];
        sb.push_back(model(mode == 1 ? 4'b1111 : (mode == 2 ? 4'b0100 : 4'b0000), 2));
        @(negedge clk);
        start     = 1'b1;
        fault_inj = (mode == 1);
        @(negedge clk);
        start = 1'b0;
        cnt   = 0;
        while (!done && cnt < 100) begin
            if (busy && (seq.size() == 0 || seq[$] != cur_vec)) seq.push_back(cur_vec);
            if (mode == 2) fault_inj = (cur_vec == 2'd2);
            @(negedge clk);
            cnt++;
        end
        e = sb.pop_front();
        chk({nm, "_latency"}, 32'(cnt), 32'(e.lat));
        chk({nm, "_fail_mask"}, 32'(fail_mask), 32'(e.mask));
        chk({nm, "_err_cnt"}, 32'(err_cnt), 32'(e.err));
        chk({nm, "_seq_len"}, 32'(seq.size()), 32'd4);
        for (int i = 0; i < seq.size() && i < 4; i++)
            chk({nm, "_cur_vec_step"}, 32'(seq[i]), 32'(i));
        @(negedge clk);
        fault_inj = 1'b0;
        chk({nm, "_pass"}, 32'(pass), 32'(e.pass));
        chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        chk({nm, "_hold_mask"}, 32'(fail_mask), 32'(e.mask));
        chk({nm, "_hold_err"}, 32'(err_cnt), 32'(e.err));
        chk({nm, "_hold_pass"}, 32'(pass), 32'(e.pass));
    endtask

    initial begin
        exp_t e;
        int   cnt, ndone, donecyc;

        rst = 1'b1; start = 1'b0; fault_inj = 1'b0;
        rst0 = 1'b1; start0 = 1'b0; fault0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_mask", 32'(fail_mask), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_vec", 32'(cur_vec), 32'd0);
        rst = 1'b0; rst0 = 1'b0;
        @(negedge clk);

        run_a(0, "clean");
        run_a(1, "fault_all");
        run_a(2, "fault_v2");

        // start alongside rst must be dropped
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rst_start_busy2", 32'(busy), 32'd0);

        // reset mid-pass
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_pass", 32'(pass), 32'd0);
        chk("mid_rst_mask", 32'(fail_mask), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        chk("mid_rst_vec", 32'(cur_vec), 32'd0);
        @(negedge clk);
        chk("mid_rst_stays_idle", 32'(busy), 32'd0);
        run_a(0, "after_rst");

        // zero-settle instance with stray starts during the pass
        sb.push_back(model(4'b0000, 0));
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0  = 1'b0;
        ndone   = 0;
        donecyc = -1;
        for (cnt = 0; cnt < 24; cnt++) begin
            if (done0) begin
                ndone++;
                if (donecyc < 0) donecyc = cnt;
            end
            start0 = (cnt == 3 || cnt == 5);
            @(negedge clk);
        end
        start0 = 1'b0;
        e = sb.pop_front();
        chk("s0_latency", 32'(donecyc), 32'(e.lat));
        chk("s0_done_count", 32'(ndone), 32'd1);
        chk("s0_pass", 32'(pass0), 32'(e.pass));
        chk("s0_mask", 32'(fail_mask0), 32'(e.mask));
        chk("s0_err", 32'(err_cnt0), 32'(e.err));
        chk("s0_busy", 32'(busy0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
